// File: rtl/tdc_tap_pkg.sv
// Shared types and constants for the delay-line tap counter.
package tdc_tap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    COUNT,
    HOLD
  } tap_state_e;

  localparam int unsigned ARM_CYC     = 3;
  localparam int unsigned ARM_CNT_W   = $clog2(ARM_CYC);
  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/tap_sync_mux.sv
// Synchronises the asynchronous tap bus, then picks one tap per channel
// through a registered mux.
module tap_sync_mux
  import tdc_tap_pkg::*;
#(
  parameter  int unsigned N_TAPS = 128,
  parameter  int unsigned N_CH   = 4,
  localparam int unsigned SEL_W  = $clog2(N_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_TAPS-1:0]     taps,
  input  logic [N_CH*SEL_W-1:0] sel,
  output logic [N_CH-1:0]       tap_out
);

  logic [SYNC_STAGES-1:0][N_TAPS-1:0] sync_d, sync_q;
  logic [N_CH-1:0]                    mux_d, mux_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = taps;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    mux_d = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      mux_d[k] = sync_q[SYNC_STAGES-1][sel[k*SEL_W +: SEL_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      mux_q  <= '0;
    end else begin
      sync_q <= sync_d;
      mux_q  <= mux_d;
    end
  end

  assign tap_out = mux_q;

endmodule

// File: rtl/tdc_tap_counter.sv
// Multi-channel gated tap counter: ARM/COUNT/HOLD measurement engine with
// saturating per-channel accumulators and a valid/ready result port.
module tdc_tap_counter
  import tdc_tap_pkg::*;
#(
  parameter  int unsigned N_TAPS = 128,
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned GATE_W = 24,
  parameter  int unsigned ACC_W  = 24,
  localparam int unsigned SEL_W  = $clog2(N_TAPS)
) (
  input  logic                  iCLK,
  input  logic                  iRESETn,
  input  logic [N_TAPS-1:0]     iTAPS,
  input  logic [N_CH*SEL_W-1:0] iSEL,
  input  logic [GATE_W-1:0]     iGATE_LEN,
  input  logic                  iEDGE_MODE,
  input  logic                  iCONT,
  input  logic                  iSTART,
  input  logic                  iABORT,
  output logic                  oBUSY,
  output logic                  oRES_VALID,
  input  logic                  iRES_READY,
  output logic [N_CH*ACC_W-1:0] oRES_DATA,
  output logic [N_CH-1:0]       oRES_OVF
);

  tap_state_e                    state_d, state_q;
  logic [ARM_CNT_W-1:0]          arm_cnt_d, arm_cnt_q;
  logic [GATE_W-1:0]             gate_cnt_d, gate_cnt_q;
  logic [N_CH*SEL_W-1:0]         sel_d, sel_q;
  logic [GATE_W-1:0]             gate_len_d, gate_len_q;
  logic                          edge_d, edge_q;
  logic                          cont_d, cont_q;
  logic [N_CH-1:0]               prev_d, prev_q;
  logic [N_CH-1:0][ACC_W-1:0]    acc_d, acc_q;
  logic [N_CH-1:0]               ovf_d, ovf_q;
  logic                          busy_d, busy_q;
  logic                          valid_d, valid_q;
  logic [N_CH-1:0]               tap_mux;
  logic [N_CH-1:0]               inc;
  logic                          latch;

  // The mux selects from the shadow copy so live iSEL changes never
  // disturb a measurement in progress.
  tap_sync_mux #(
    .N_TAPS (N_TAPS),
    .N_CH   (N_CH)
  ) u_sync_mux (
    .clk     (iCLK),
    .rst_n   (iRESETn),
    .taps    (iTAPS),
    .sel     (sel_q),
    .tap_out (tap_mux)
  );

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    gate_cnt_d = gate_cnt_q;
    sel_d      = sel_q;
    gate_len_d = gate_len_q;
    edge_d     = edge_q;
    cont_d     = cont_q;
    prev_d     = prev_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    inc        = '0;
    latch      = 1'b0;

    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = ARM;
          latch   = 1'b1;
        end
      end
      ARM: begin
        acc_d     = '0;
        ovf_d     = '0;
        arm_cnt_d = arm_cnt_q + ARM_CNT_W'(1);
        if (arm_cnt_q == ARM_CNT_W'(ARM_CYC - 1)) begin
          prev_d     = tap_mux;
          gate_cnt_d = gate_len_q;
          state_d    = (gate_len_q != '0) ? COUNT : HOLD;
        end
      end
      COUNT: begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          inc[k] = edge_q ? (tap_mux[k] ^ prev_q[k]) : tap_mux[k];
          if (inc[k]) begin
            if (&acc_q[k]) ovf_d[k] = 1'b1;
            else           acc_d[k] = acc_q[k] + ACC_W'(1);
          end
        end
        prev_d     = tap_mux;
        gate_cnt_d = gate_cnt_q - GATE_W'(1);
        if (gate_cnt_q == GATE_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        if (iRES_READY) begin
          if (cont_q) begin
            state_d = ARM;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (latch) begin
      sel_d      = iSEL;
      gate_len_d = iGATE_LEN;
      edge_d     = iEDGE_MODE;
      cont_d     = iCONT;
      arm_cnt_d  = '0;
    end

    if (iABORT) state_d = IDLE;

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      gate_cnt_q <= '0;
      sel_q      <= '0;
      gate_len_q <= '0;
      edge_q     <= 1'b0;
      cont_q     <= 1'b0;
      prev_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      sel_q      <= sel_d;
      gate_len_q <= gate_len_d;
      edge_q     <= edge_d;
      cont_q     <= cont_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign oBUSY      = busy_q;
  assign oRES_VALID = valid_q;
  assign oRES_DATA  = acc_q;
  assign oRES_OVF   = ovf_q;

endmodule

// File: tb/tb_tdc_tap_counter.sv
// Scoreboard bench for tdc_tap_counter (small build: 16 taps, 9-bit gate, 8-bit acc).
module tb_tdc_tap_counter;

  localparam int unsigned N_TAPS = 16;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned GATE_W = 9;
  localparam int unsigned ACC_W  = 8;
  localparam int unsigned SEL_W  = 4;

  logic                  iCLK = 1'b0;
  logic                  iRESETn;
  logic [N_TAPS-1:0]     iTAPS = '0;
  logic [N_CH*SEL_W-1:0] iSEL;
  logic [GATE_W-1:0]     iGATE_LEN;
  logic                  iEDGE_MODE;
  logic                  iCONT;
  logic                  iSTART;
  logic                  iABORT;
  logic                  oBUSY;
  logic                  oRES_VALID;
  logic                  iRES_READY;
  logic [N_CH*ACC_W-1:0] oRES_DATA;
  logic [N_CH-1:0]       oRES_OVF;

  tdc_tap_counter #(
    .N_TAPS (N_TAPS),
    .N_CH   (N_CH),
    .GATE_W (GATE_W),
    .ACC_W  (ACC_W)
  ) dut (
    .iCLK       (iCLK),
    .iRESETn    (iRESETn),
    .iTAPS      (iTAPS),
    .iSEL       (iSEL),
    .iGATE_LEN  (iGATE_LEN),
    .iEDGE_MODE (iEDGE_MODE),
    .iCONT      (iCONT),
    .iSTART     (iSTART),
    .iABORT     (iABORT),
    .oBUSY      (oBUSY),
    .oRES_VALID (oRES_VALID),
    .iRES_READY (iRES_READY),
    .oRES_DATA  (oRES_DATA),
    .oRES_OVF   (oRES_OVF)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Tap stimulus is a pure function of the cycle index so the model can replay it.
  int                tap_mode = 0;
  int                phase    = 0;
  logic [N_TAPS-1:0] tap_static = 16'hA5A0;

  function automatic logic [N_TAPS-1:0] tap_at(input int c);
    logic [N_TAPS-1:0] v;
    int t;
    v = tap_static;
    t = (c + phase) >> 2;
    case (tap_mode)
      1:       v[0] = c[0];
      2:       v[0] = t[0];
      default: ;
    endcase
    return v;
  endfunction

  initial forever begin
    @(negedge iCLK);
    iTAPS = tap_at(cyc);
  end

  typedef struct {
    logic [N_CH-1:0][ACC_W-1:0] cnt;
    logic [N_CH-1:0]            ovf;
    int                         start;
    int                         gate;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Prev sample is the tap in the start cycle; the next g cycles are counted.
  function automatic exp_t model(input int start, input logic [N_CH*SEL_W-1:0] sel,
                                 input int g, input logic edge_m);
    exp_t              e;
    logic [N_TAPS-1:0] v;
    logic [SEL_W-1:0]  s;
    logic              prev, b, incr;
    e.start = start;
    e.gate  = g;
    e.cnt   = '0;
    e.ovf   = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      s    = sel[k*SEL_W +: SEL_W];
      v    = tap_at(start);
      prev = v[s];
      for (int i = 1; i <= g; i++) begin
        v    = tap_at(start + i);
        b    = v[s];
        incr = edge_m ? (b ^ prev) : b;
        prev = b;
        if (incr) begin
          if (e.cnt[k] == {ACC_W{1'b1}}) e.ovf[k] = 1'b1;
          else                           e.cnt[k] = e.cnt[k] + 1'b1;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [N_CH*SEL_W-1:0] pack_sel(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic start_meas(input logic [N_CH*SEL_W-1:0] sel, input int g,
                            input logic edge_m, input logic cont);
    iSEL       = sel;
    iGATE_LEN  = GATE_W'(g);
    iEDGE_MODE = edge_m;
    iCONT      = cont;
    iSTART     = 1'b1;
    sb.push_back(model(cyc, sel, g, edge_m));
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (oRES_VALID !== 1'b1 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    if (oRES_VALID !== 1'b1) check_eq("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb[0];
    check_eq("latency", 64'(cyc - e.start), 64'(e.gate + 4));
    for (int k = 0; k < int'(N_CH); k++)
      check_eq($sformatf("cnt_ch%0d", k), 64'(oRES_DATA[k*ACC_W +: ACC_W]), 64'(e.cnt[k]));
    check_eq("ovf", 64'(oRES_OVF), 64'(e.ovf));
  endtask

  task automatic handshake(input logic rearm);
    iRES_READY = 1'b1;
    if (rearm) sb.push_back(model(cyc, iSEL, int'(iGATE_LEN), iEDGE_MODE));
    @(negedge iCLK);
    iRES_READY = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    check_eq("valid_drop", 64'(oRES_VALID), 64'd0);
  endtask

  task automatic drop_head();
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    iRESETn = 1'b0; iSEL = '0; iGATE_LEN = '0; iEDGE_MODE = 1'b0; iCONT = 1'b0;
    iSTART = 1'b0; iABORT = 1'b0; iRES_READY = 1'b0;
    repeat (3) @(negedge iCLK);
    check_eq("rst_busy", 64'(oBUSY), 64'd0);
    check_eq("rst_valid", 64'(oRES_VALID), 64'd0);
    check_eq("rst_data", 64'(oRES_DATA), 64'd0);
    check_eq("rst_ovf", 64'(oRES_OVF), 64'd0);
    iRESETn = 1'b1;
    repeat (5) @(negedge iCLK);

    // Level mode, static taps: tap5=1, tap6=0, tap7=1, tap0=0.
    start_meas(pack_sel(5, 6, 7, 0), 100, 1'b0, 1'b0);
    wait_valid(200);
    compare_head();
    check_eq("lvl_ch0_100", 64'(oRES_DATA[ACC_W-1:0]), 64'd100);
    handshake(1'b0);
    check_eq("lvl_idle", 64'(oBUSY), 64'd0);

    // Edge mode, tap 0 toggling every cycle.
    tap_mode = 1;
    repeat (3) @(negedge iCLK);
    start_meas(pack_sel(0, 5, 6, 0), 50, 1'b1, 1'b0);
    wait_valid(200);
    compare_head();
    check_eq("edge_ch0_50", 64'(oRES_DATA[ACC_W-1:0]), 64'd50);
    handshake(1'b0);

    // Edge mode, tap 0 toggling every 4 cycles with a random phase.
    tap_mode = 2;
    phase    = int'($urandom_range(0, 3));
    repeat (3) @(negedge iCLK);
    start_meas(pack_sel(0, 5, 0, 7), 50, 1'b1, 1'b0);
    wait_valid(200);
    compare_head();
    handshake(1'b0);

    // Saturation at 8 bits.
    tap_mode = 0;
    repeat (3) @(negedge iCLK);
    start_meas(pack_sel(5, 6, 7, 6), 300, 1'b0, 1'b0);
    wait_valid(400);
    compare_head();
    check_eq("sat_ch0", 64'(oRES_DATA[ACC_W-1:0]), 64'd255);
    check_eq("sat_ovf", 64'(oRES_OVF), 64'b0101);
    handshake(1'b0);

    // Zero gate length.
    start_meas(pack_sel(5, 7, 5, 7), 0, 1'b0, 1'b0);
    wait_valid(20);
    compare_head();
    check_eq("g0_data", 64'(oRES_DATA), 64'd0);
    handshake(1'b0);

    // Start pulses and input changes while busy must not disturb the gate.
    start_meas(pack_sel(5, 6, 7, 0), 50, 1'b0, 1'b0);
    repeat (10) @(negedge iCLK);
    iSTART = 1'b1; iGATE_LEN = GATE_W'(200); iSEL = pack_sel(6, 5, 0, 7);
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (20) @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    wait_valid(200);
    compare_head();
    handshake(1'b0);

    // All-ones gate length, edge mode on the slow toggle.
    tap_mode = 2;
    repeat (3) @(negedge iCLK);
    start_meas(pack_sel(0, 5, 0, 6), (1 << GATE_W) - 1, 1'b1, 1'b0);
    wait_valid(600);
    compare_head();
    handshake(1'b0);

    // Continuous mode; iCONT dropped mid-measurement, ready held off in HOLD.
    tap_mode = 0;
    repeat (3) @(negedge iCLK);
    start_meas(pack_sel(5, 6, 7, 0), 30, 1'b0, 1'b1);
    repeat (10) @(negedge iCLK);
    iCONT = 1'b0;
    wait_valid(100);
    compare_head();
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      check_eq("hold_valid", 64'(oRES_VALID), 64'd1);
      if (sb.size() > 0) check_eq("hold_data", 64'(oRES_DATA), 64'(sb[0].cnt));
      if (i == 10) begin
        iSEL      = pack_sel(0, 5, 6, 5);
        iGATE_LEN = GATE_W'(25);
      end
    end
    handshake(1'b1);
    check_eq("cont_rearm_busy", 64'(oBUSY), 64'd1);
    wait_valid(100);
    compare_head();
    handshake(1'b0);
    check_eq("cont_stop_busy", 64'(oBUSY), 64'd0);

    // Abort mid-COUNT.
    start_meas(pack_sel(5, 6, 7, 0), 100, 1'b0, 1'b0);
    repeat (20) @(negedge iCLK);
    iABORT = 1'b1;
    @(negedge iCLK);
    iABORT = 1'b0;
    check_eq("abort_busy", 64'(oBUSY), 64'd0);
    check_eq("abort_valid", 64'(oRES_VALID), 64'd0);
    drop_head();
    repeat (3) @(negedge iCLK);

    // Start and abort together in IDLE.
    iSTART = 1'b1; iABORT = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0; iABORT = 1'b0;
    check_eq("start_abort_busy", 64'(oBUSY), 64'd0);
    repeat (2) @(negedge iCLK);
    check_eq("start_abort_idle", 64'(oBUSY), 64'd0);

    // Reset while holding a result.
    start_meas(pack_sel(5, 7, 5, 7), 10, 1'b0, 1'b0);
    wait_valid(50);
    compare_head();
    iRESETn = 1'b0;
    @(negedge iCLK);
    check_eq("hrst_busy", 64'(oBUSY), 64'd0);
    check_eq("hrst_valid", 64'(oRES_VALID), 64'd0);
    check_eq("hrst_data", 64'(oRES_DATA), 64'd0);
    check_eq("hrst_ovf", 64'(oRES_OVF), 64'd0);
    iRESETn = 1'b1;
    drop_head();
    repeat (3) @(negedge iCLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
